// File: rtl/frame_marker_deframer_if.sv
// Serial deframer bus: gated bit input plus payload/status outputs.
// master drives the serial stream, slave is the deframer.
interface frame_marker_deframer_if;
    logic IN;
    logic VALID_IN;
    logic OUT;
    logic VALID_OUT;
    logic FRAME_START;
    logic LOCKED;
    logic MARKER_ERR;

    modport master (
        output IN,
        output VALID_IN,
        input  OUT,
        input  VALID_OUT,
        input  FRAME_START,
        input  LOCKED,
        input  MARKER_ERR
    );

    modport slave (
        input  IN,
        input  VALID_IN,
        output OUT,
        output VALID_OUT,
        output FRAME_START,
        output LOCKED,
        output MARKER_ERR
    );
endinterface

// File: rtl/frame_marker_deframer.sv
// Serial frame deframer: hunts a 32-bit sync marker, locks, strips it
// and forwards payload bits; a flywheel rides out isolated bad markers.
module frame_marker_deframer #(
    parameter int          BYTES_IN_FRAME = 32,
    parameter logic [31:0] MARKER         = 32'hAA550100,
    parameter int          LOCK_MISSES    = 2
) (
    input  logic                   CLK,
    input  logic                   RST,
    frame_marker_deframer_if.slave bus
);
    localparam int FRAME_BITS = 8 * BYTES_IN_FRAME;
    localparam int CW         = $clog2(FRAME_BITS);

    localparam logic [CW-1:0] LAST_BIT   = CW'(FRAME_BITS - 1);
    localparam logic [CW-1:0] LAST_MK    = CW'(31);
    localparam logic [3:0]    MISS_LIMIT = 4'(LOCK_MISSES);

    typedef enum logic [1:0] {
        ST_HUNT,
        ST_PAYLOAD,
        ST_MARK
    } state_t;

    state_t        state;
    state_t        state_d;
    logic [31:0]   sr;
    logic [31:0]   window;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_d;
    logic [3:0]    miss;
    logic [3:0]    miss_d;
    logic [3:0]    miss_inc;
    logic          hit;
    logic          mk_end;
    logic          out_d;
    logic          vout_d;
    logic          fs_d;
    logic          err_d;
    logic          lock_d;

    // The live window includes the bit arriving this cycle.
    assign window   = {sr[30:0], bus.IN};
    assign hit      = (window == MARKER);
    assign mk_end   = (cnt == LAST_MK);
    assign miss_inc = miss + 4'd1;

    // All state and registered outputs; nothing but strobes moves on idle cycles.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state           <= ST_HUNT;
            sr              <= '0;
            cnt             <= '0;
            miss            <= '0;
            bus.OUT         <= 1'b0;
            bus.VALID_OUT   <= 1'b0;
            bus.FRAME_START <= 1'b0;
            bus.LOCKED      <= 1'b0;
            bus.MARKER_ERR  <= 1'b0;
        end else begin
            state           <= state_d;
            cnt             <= cnt_d;
            miss            <= miss_d;
            if (bus.VALID_IN) begin
                sr <= window;
            end
            bus.OUT         <= out_d;
            bus.VALID_OUT   <= vout_d;
            bus.FRAME_START <= fs_d;
            bus.LOCKED      <= lock_d;
            bus.MARKER_ERR  <= err_d;
        end
    end

    // Next state, bit counter and flywheel miss counter.
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        miss_d  = miss;
        if (bus.VALID_IN) begin
            unique case (state)
                ST_HUNT: begin
                    if (hit) begin
                        state_d = ST_PAYLOAD;
                        cnt_d   = '0;
                        miss_d  = '0;
                    end
                end
                ST_PAYLOAD: begin
                    if (cnt == LAST_BIT) begin
                        state_d = ST_MARK;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt + 1'b1;
                    end
                end
                ST_MARK: begin
                    if (mk_end) begin
                        cnt_d = '0;
                        if (hit) begin
                            miss_d  = '0;
                            state_d = ST_PAYLOAD;
                        end else if (miss_inc == MISS_LIMIT) begin
                            miss_d  = '0;
                            state_d = ST_HUNT;
                        end else begin
                            miss_d  = miss_inc;
                            state_d = ST_PAYLOAD;
                        end
                    end else begin
                        cnt_d = cnt + 1'b1;
                    end
                end
                default: begin
                    state_d = ST_HUNT;
                end
            endcase
        end
    end

    // Output values to register: payload bit, strobes and lock flag.
    always_comb begin
        out_d  = bus.OUT;
        vout_d = 1'b0;
        fs_d   = 1'b0;
        err_d  = 1'b0;
        lock_d = bus.LOCKED;
        if (bus.VALID_IN) begin
            unique case (state)
                ST_HUNT: begin
                    if (hit) begin
                        lock_d = 1'b1;
                    end
                end
                ST_PAYLOAD: begin
                    out_d  = bus.IN;
                    vout_d = 1'b1;
                    fs_d   = (cnt == '0);
                end
                ST_MARK: begin
                    if (mk_end && !hit) begin
                        err_d = 1'b1;
                        if (miss_inc == MISS_LIMIT) begin
                            lock_d = 1'b0;
                        end
                    end
                end
                default: begin
                    lock_d = 1'b0;
                end
            endcase
        end
    end
endmodule

// File: doc/frame_marker_deframer.md
Name: frame_marker_deframer

Overview:
- Receive-side counterpart of the 1020-to-1024 serial framer.
- Takes a gated serial bit stream in which every frame is a 32-bit sync marker 0xAA550100, sent MSB-first, followed by 8*BYTES_IN_FRAME payload bits.
- Hunts for the marker, locks onto frame timing, strips the marker and forwards only payload bits with a valid strobe.
- Tolerates isolated corrupted markers with a flywheel miss counter before dropping lock.

Parameters:
- BYTES_IN_FRAME, 32, payload bytes per frame; production value is 1020.
- MARKER, 32'hAA550100, sync word, compared MSB-first.
- LOCK_MISSES, 2, consecutive bad markers that force a return to HUNT; legal range 1..15.

Ports:
- CLK  in  1  single clock; all logic on rising edge.
- RST  in  1  synchronous, active-high reset.
- IN  in  1  serial data bit, MSB of each byte first.
- VALID_IN  in  1  IN is sampled only in cycles where VALID_IN=1.
- OUT  out  1  payload bit, registered.
- VALID_OUT  out  1  OUT carries a payload bit this cycle.
- FRAME_START  out  1  one-cycle pulse, coincident with VALID_OUT of the first payload bit of each frame.
- LOCKED  out  1  frame timing acquired.
- MARKER_ERR  out  1  one-cycle pulse when a marker expected while locked does not match.

Behaviour:
- Reset: OUT, VALID_OUT, FRAME_START, LOCKED and MARKER_ERR = 0. State = HUNT. Shift register, bit counter and miss counter = 0. MARKER is nonzero, so a cleared shift register cannot false-match. Reset mid-frame discards the frame.
- All state advances only on VALID_IN=1. When VALID_IN=0, everything holds, and VALID_OUT, FRAME_START and MARKER_ERR are 0 next cycle.
- Window: 32-bit shift register, sr <= {sr[30:0], IN} on every valid bit in every state. The comparison window is {sr[30:0], IN}, i.e. the current bit plus the previous 31.
- HUNT:
  - On a valid bit, if window == MARKER, go to PAYLOAD, set bit counter = 0, clear miss counter, set LOCKED = 1 next cycle.
  - Marker bits are never output.
- PAYLOAD:
  - On each valid bit: OUT <= IN, VALID_OUT <= 1, counter++.
  - FRAME_START <= 1 when counter == 0.
  - On counter == 8*BYTES_IN_FRAME-1: output the bit, go to MARKER, set counter = 0.
  - A marker pattern inside the payload is ignored and passed through as data.
- MARKER:
  - Counts 32 valid bits with no output.
  - On the 32nd bit, compare the window to MARKER:
    - Match: clear miss counter, go to PAYLOAD.
    - Mismatch: MARKER_ERR pulses next cycle and miss counter increments.
      - If the new miss count == LOCK_MISSES: go to HUNT, LOCKED <= 0, clear miss counter.
      - Otherwise (flywheel): go to PAYLOAD and treat the following bits as payload.
- Latency: exactly one clock from a valid input bit to the corresponding OUT/VALID_OUT.
- Widths:
  - Bit counter is $clog2(8*BYTES_IN_FRAME) bits and is compared against the full terminal value; no reliance on natural wrap.
  - Miss counter is 4 bits.
- Return to HUNT: searching starts with the next valid bit, using the live window. The shift register is not cleared.

Test Plan:
- Locked frames: reset, then send two frames back-to-back with continuous VALID_IN, BYTES_IN_FRAME=32, payload bytes 0x00..0x1F.
  -> LOCKED=1 one cycle after the 32nd marker bit.
  -> 256 VALID_OUT bits per frame, equal to the payload MSB-first.
  -> FRAME_START pulses exactly twice.
  -> No marker bit appears on OUT.
- Leading noise: 13 random bits before the first marker -> VALID_OUT and LOCKED stay 0 until the marker completes, then behaviour is as in the locked-frames scenario.
- Input gaps: VALID_IN toggling 1/0 every cycle over the same stream -> identical payload bit sequence; VALID_OUT high only in cycles after VALID_IN=1.
- Marker errors, LOCK_MISSES=2:
  - Second marker sent as 0xAA550101 -> MARKER_ERR one pulse, LOCKED stays 1, frame-2 payload still output.
  - Second and third markers both corrupted -> LOCKED falls after the second miss.
  - The next good marker relocks, and FRAME_START resumes.
- Marker in payload: payload containing 0xAA550100 at byte offset 5 while locked -> bits passed through unchanged, no resync, no MARKER_ERR.
- Reset mid-operation: RST asserted mid-payload -> next cycle OUT, VALID_OUT, LOCKED and FRAME_START = 0; relock occurs only on the next complete marker after reset release.
